// File: rtl/dma_req_arbiter.sv
// Four-channel DMA request arbiter with HRQ/HLDA bus-hold handshake and per-channel byte counters.
// Latency: dreq->hrq 1 cycle, hlda->dack 1 cycle, last xfer_done->ch_done/dack low 1 cycle.
// Backpressure: host stalls via hlda; FIXED_PRIO_EN selects fixed priority instead of round-robin.
module dma_req_arbiter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   dreq,
  input  logic             hlda,
  input  logic             xfer_done,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             hrq,
  output logic [NCH-1:0]   dack,
  output logic [1:0]       dsel,
  output logic             busy,
  output logic [NCH-1:0]   ch_done,
  output logic [CNT_W-1:0] cnt_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       dsel_q, dsel_d;
  logic             hrq_q, hrq_d;
  logic [NCH-1:0]   dack_q, dack_d;
  logic             busy_q, busy_d;
  logic [NCH-1:0]   ch_done_q, ch_done_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  logic [NCH-1:0]   elig;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic             owned;
  logic             dec_en;
  logic             last_byte;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = dreq[i] && (cnt_q[i] != '0);
    end
  end

`ifdef FIXED_PRIO_EN
  // Scan downward so the lowest-numbered eligible channel is the last assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Offsets from the pointer wrap naturally in the 2-bit index; smallest offset wins.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end
`endif

  assign owned     = (state_q == S_REQ) || (state_q == S_XFER);
  assign dec_en    = (state_q == S_XFER) && xfer_done && (cnt_q[dsel_q] != '0);
  assign last_byte = dec_en && (cnt_q[dsel_q] == CNT_W'(1));

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dec_en && (dsel_q == 2'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (cfg_we && (cfg_ch == 2'(i)) && !(owned && (dsel_q == 2'(i)))) begin
        cnt_d[i] = cfg_count;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dsel_d    = dsel_q;
    hrq_d     = hrq_q;
    dack_d    = dack_q;
    busy_d    = busy_q;
    ch_done_d = '0;
`ifndef FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          dsel_d  = win_idx;
          hrq_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!dreq[dsel_q]) begin
          hrq_d   = 1'b0;
          state_d = S_REL;
        end else if (hlda) begin
          dack_d         = '0;
          dack_d[dsel_q] = 1'b1;
          state_d        = S_XFER;
        end
      end
      S_XFER: begin
        if (last_byte) begin
          ch_done_d[dsel_q] = 1'b1;
          dack_d            = '0;
          hrq_d             = 1'b0;
          state_d           = S_REL;
        end else if (!dreq[dsel_q] || !hlda) begin
          dack_d  = '0;
          hrq_d   = 1'b0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        hrq_d  = 1'b0;
        dack_d = '0;
        if (!hlda) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifndef FIXED_PRIO_EN
          ptr_d   = dsel_q + 2'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dsel_q    <= '0;
      hrq_q     <= 1'b0;
      dack_q    <= '0;
      busy_q    <= 1'b0;
      ch_done_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
`ifndef FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      hrq_q     <= hrq_d;
      dack_q    <= dack_d;
      busy_q    <= busy_d;
      ch_done_q <= ch_done_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifndef FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign hrq     = hrq_q;
  assign dack    = dack_q;
  assign dsel    = dsel_q;
  assign busy    = busy_q;
  assign ch_done = ch_done_q;
  assign cnt_rd  = cnt_q[cfg_ch];

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Bench for dma_req_arbiter: expected grant channels are queued as requests are raised and popped on grant.
module tb_dma_req_arbiter;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       dreq = '0;
  logic             hlda = 1'b0;
  logic             xfer_done = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             hrq;
  logic [3:0]       dack;
  logic [1:0]       dsel;
  logic             busy;
  logic [3:0]       ch_done;
  logic [CNT_W-1:0] cnt_rd;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  dma_req_arbiter #(.NCH(4), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .dreq      (dreq),
    .hlda      (hlda),
    .xfer_done (xfer_done),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_count (cfg_count),
    .hrq       (hrq),
    .dack      (dack),
    .dsel      (dsel),
    .busy      (busy),
    .ch_done   (ch_done),
    .cnt_rd    (cnt_rd)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic write_cnt(input logic [1:0] ch, input logic [CNT_W-1:0] v);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_count = v;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (hrq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Waits for a grant, checks it against the scoreboard, then ends it by
  // exhausting the count (end_hlda=0) or by the host dropping hlda (end_hlda=1).
  task automatic serve(input int nbytes, input bit end_hlda);
    bit         ok;
    int         exp_ch;
    logic [3:0] exp_dack;
    wait_hrq(ok);
    n_total++;
    if (!ok) $display("FAIL serve_hrq_timeout: hrq=%0b want 1", hrq);
    else n_pass++;
    exp_ch = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_total++;
    if (exp_ch < 0 || dsel !== 2'(exp_ch)) $display("FAIL grant_order: dsel=%0d want %0d", dsel, exp_ch);
    else n_pass++;
    exp_dack = 4'b0001 << exp_ch;
    hlda = 1'b1;
    cyc();
    n_total++;
    if (dack !== exp_dack) $display("FAIL grant_dack: dack=%b want %b", dack, exp_dack);
    else n_pass++;
    for (int b = 0; b < nbytes; b++) begin
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      if (b < nbytes - 1) cyc();
    end
    if (!end_hlda) begin
      n_total++;
      if ({ch_done, dack, hrq, busy} !== {exp_dack, 4'b0000, 1'b0, 1'b1})
        $display("FAIL done_pulse: ch_done=%b dack=%b hrq=%b busy=%b want %b 0000 0 1", ch_done, dack, hrq, busy, exp_dack);
      else n_pass++;
      hlda = 1'b0;
      cyc();
      n_total++;
      if ({ch_done, busy} !== 5'b0) $display("FAIL done_idle: ch_done=%b busy=%b want 0000 0", ch_done, busy);
      else n_pass++;
    end else begin
      hlda = 1'b0;
      cyc();
      n_total++;
      if ({dack, hrq, ch_done} !== 9'b0) $display("FAIL hlda_drop: dack=%b hrq=%b ch_done=%b want all 0", dack, hrq, ch_done);
      else n_pass++;
      cyc();
      n_total++;
      if (busy !== 1'b0) $display("FAIL hlda_idle: busy=%b want 0", busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    n_total++;
    if ({hrq, dack, dsel, busy, ch_done} !== 12'b0)
      $display("FAIL reset_outputs: hrq=%b dack=%b dsel=%0d busy=%b ch_done=%b want all 0", hrq, dack, dsel, busy, ch_done);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1;
      n_total++;
      if (cnt_rd !== 8'd0) $display("FAIL reset_count ch%0d: cnt=%0d want 0", c, cnt_rd);
      else n_pass++;
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_single_channel();
    write_cnt(2'd2, 8'd3);
    n_total++;
    if (cnt_rd !== 8'd3) $display("FAIL cfg_load: cnt=%0d want 3", cnt_rd);
    else n_pass++;
    dreq = 4'b0100;
    exp_q.push_back(2);
    cyc();
    n_total++;
    if ({hrq, busy, dack} !== {1'b1, 1'b1, 4'b0000})
      $display("FAIL dreq_to_hrq: hrq=%b busy=%b dack=%b want 1 1 0000", hrq, busy, dack);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0 || dsel !== 2'(exp_q.pop_front())) $display("FAIL single_dsel: dsel=%0d want 2", dsel);
    else n_pass++;
    hlda = 1'b1;
    cyc();
    n_total++;
    if ({dack, dsel} !== {4'b0100, 2'd2}) $display("FAIL hlda_to_dack: dack=%b dsel=%0d want 0100 2", dack, dsel);
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      n_total++;
      if (cnt_rd !== 8'(2 - b)) $display("FAIL count_dec byte%0d: cnt=%0d want %0d", b, cnt_rd, 2 - b);
      else n_pass++;
      if (b < 2) cyc();
    end
    n_total++;
    if ({ch_done, hrq, dack} !== {4'b0100, 1'b0, 4'b0000})
      $display("FAIL single_done: ch_done=%b hrq=%b dack=%b want 0100 0 0000", ch_done, hrq, dack);
    else n_pass++;
    dreq = 4'b0000;
    hlda = 1'b0;
    cyc();
    n_total++;
    if ({ch_done, busy} !== 5'b0) $display("FAIL single_idle: ch_done=%b busy=%b want 0000 0", ch_done, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    write_cnt(2'd0, 8'd1);
    write_cnt(2'd1, 8'd1);
    dreq = 4'b0011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    serve(1, 1'b0);
    serve(1, 1'b0);
    dreq = 4'b0000;
    write_cnt(2'd0, 8'd2);
    write_cnt(2'd1, 8'd1);
    dreq = 4'b0011;
`ifdef FIXED_PRIO_EN
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(0);
`endif
    serve(1, 1'b1);
    serve(1, 1'b0);
    serve(1, 1'b0);
    dreq = 4'b0000;
  endtask

  task automatic test_zero_count();
    bit seen;
    seen = 1'b0;
    dreq = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (hrq !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL zero_count_blocked: hrq seen=1 want 0");
    else n_pass++;
    write_cnt(2'd3, 8'd5);
    cyc();
    n_total++;
    if (hrq !== 1'b1) $display("FAIL zero_count_enable: hrq=%b want 1", hrq);
    else n_pass++;
    exp_q.push_back(3);
    serve(0, 1'b1);
    dreq = 4'b0000;
    cfg_ch = 2'd3;
    #1;
    n_total++;
    if (cnt_rd !== 8'd5) $display("FAIL zero_count_retain: cnt=%0d want 5", cnt_rd);
    else n_pass++;
  endtask

  task automatic test_demand();
    bit ok;
    write_cnt(2'd1, 8'd5);
    dreq = 4'b0010;
    exp_q.push_back(1);
    wait_hrq(ok);
    n_total++;
    if (!ok || exp_q.size() == 0 || dsel !== 2'(exp_q.pop_front()))
      $display("FAIL demand_grant: hrq=%b dsel=%0d want 1 1", hrq, dsel);
    else n_pass++;
    hlda = 1'b1;
    cyc();
    xfer_done = 1'b1;
    cyc();
    xfer_done = 1'b0;
    dreq = 4'b0000;
    cyc();
    cfg_ch = 2'd1;
    #1;
    n_total++;
    if ({dack, hrq, ch_done, cnt_rd} !== {4'b0000, 1'b0, 4'b0000, 8'd4})
      $display("FAIL demand_release: dack=%b hrq=%b ch_done=%b cnt=%0d want 0000 0 0000 4", dack, hrq, ch_done, cnt_rd);
    else n_pass++;
    hlda = 1'b0;
    cyc();
    dreq = 4'b0010;
    exp_q.push_back(1);
    serve(0, 1'b1);
    dreq = 4'b0000;
    n_total++;
    if (cnt_rd !== 8'd4) $display("FAIL demand_regrant_count: cnt=%0d want 4", cnt_rd);
    else n_pass++;
  endtask

  task automatic test_cfg_during_xfer();
    bit ok;
    write_cnt(2'd0, 8'd3);
    dreq = 4'b0001;
    exp_q.push_back(0);
    wait_hrq(ok);
    n_total++;
    if (!ok || exp_q.size() == 0 || dsel !== 2'(exp_q.pop_front()))
      $display("FAIL cfg_grant: hrq=%b dsel=%0d want 1 0", hrq, dsel);
    else n_pass++;
    hlda = 1'b1;
    cyc();
    write_cnt(2'd0, 8'd9);
    n_total++;
    if (cnt_rd !== 8'd3) $display("FAIL cfg_granted_ignored: cnt=%0d want 3", cnt_rd);
    else n_pass++;
    xfer_done = 1'b1;
    write_cnt(2'd2, 8'd7);
    xfer_done = 1'b0;
    n_total++;
    if (cnt_rd !== 8'd7) $display("FAIL cfg_other_accepted: cnt=%0d want 7", cnt_rd);
    else n_pass++;
    cfg_ch = 2'd0;
    #1;
    n_total++;
    if ({cnt_rd, dack} !== {8'd2, 4'b0001}) $display("FAIL cfg_same_cycle_dec: cnt=%0d dack=%b want 2 0001", cnt_rd, dack);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cyc();
    n_total++;
    if ({hrq, busy} !== 2'b11) $display("FAIL pre_reset_active: hrq=%b busy=%b want 1 1", hrq, busy);
    else n_pass++;
    #3;
    reset = 1'b0;
    #1;
    n_total++;
    if ({hrq, dack, busy} !== 6'b0) $display("FAIL async_reset: hrq=%b dack=%b busy=%b want 0 0000 0", hrq, dack, busy);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1;
      n_total++;
      if (cnt_rd !== 8'd0) $display("FAIL async_reset_count ch%0d: cnt=%0d want 0", c, cnt_rd);
      else n_pass++;
    end
    dreq = 4'b0000;
    hlda = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_hlda_drop();
    write_cnt(2'd1, 8'd2);
    dreq = 4'b0010;
    exp_q.push_back(1);
    serve(1, 1'b1);
    dreq = 4'b0000;
    cfg_ch = 2'd1;
    #1;
    n_total++;
    if (cnt_rd !== 8'd1) $display("FAIL hlda_drop_retain: cnt=%0d want 1", cnt_rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_zero_count();
    test_demand();
    test_cfg_during_xfer();
    test_async_reset();
    test_hlda_drop();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/dma_req_arbiter.md
Name: dma_req_arbiter

Overview:
- Upstream front end of the DMA subsystem. Arbitrates the four IO-device DMA requests and runs the HRQ/HLDA bus-hold handshake with the host.
- Drives per-channel acknowledge and the 2-bit channel select into the DMA SPI master.
- Holds a programmable per-channel byte count. Signals completion per channel once the master has moved that many bytes.

Parameters:
- NCH, 4, number of DMA channels; only 4 is supported, and dsel is 2 bits wide.
- CNT_W, 8, width of each channel's remaining-byte counter.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- dreq  input  4  DMA request, one bit per IO device; level-sensitive
- hlda  input  1  hold acknowledge from host
- xfer_done  input  1  one-cycle pulse from SPI master, one per completed byte
- cfg_we  input  1  count-register write strobe
- cfg_ch  input  2  channel addressed by cfg_we
- cfg_count  input  CNT_W  byte count to load
- hrq  output  1  hold request to host
- dack  output  4  one-hot DMA acknowledge; at most one bit high
- dsel  output  2  index of the granted channel
- busy  output  1  high in REQ, XFER and RELEASE
- ch_done  output  4  one-cycle pulse when a channel's count reaches 0
- cnt_rd  output  CNT_W  remaining count of the channel selected by cfg_ch (combinational read)

Behaviour:
- Reset (reset=0, asynchronous):
  - hrq=0, dack=0, dsel=0, busy=0, ch_done=0.
  - All counts=0; round-robin pointer=0; state=IDLE.
- Eligibility: channel i is eligible when dreq[i]=1 and count[i]!=0. A count of 0 disables the channel.
- Config writes:
  - cfg_we loads count[cfg_ch]=cfg_count on the next edge.
  - A write to the currently granted channel while in REQ/XFER is ignored.
  - A write to any other channel is always accepted, including in the same cycle as xfer_done.
- IDLE:
  - If any channel is eligible, pick the winner by round-robin starting at the pointer.
  - On the next edge: latch the winner into dsel, set hrq=1, busy=1, go to REQ.
- REQ:
  - Hold hrq=1 until hlda is sampled 1.
  - On that edge: dack[dsel]=1, go to XFER.
  - If dreq[dsel] drops before hlda: hrq=0, go to RELEASE.
- XFER:
  - Each xfer_done pulse decrements count[dsel].
  - If xfer_done arrives with count==1: on the next edge count=0, ch_done[dsel]=1 for one cycle, dack=0, hrq=0, go to RELEASE.
  - If dreq[dsel] drops (demand mode): dack=0, hrq=0, go to RELEASE; count is retained.
  - If xfer_done and the dreq drop occur in the same cycle: the decrement is applied first, then RELEASE.
  - If hlda drops (host reclaims the bus): dack=0, hrq=0, go to RELEASE; count is retained.
  - xfer_done outside XFER is ignored.
- RELEASE:
  - hrq=0, dack=0.
  - Wait for hlda==0, then go to IDLE with busy=0.
  - The round-robin pointer becomes (dsel+1) mod 4.
- Latency:
  - dreq to hrq: 1 cycle.
  - hlda to dack: 1 cycle.
  - Last xfer_done to ch_done/dack low: 1 cycle.
  - A new arbitration can start no earlier than the cycle after IDLE is re-entered.
- The counter never underflows; decrement at 0 cannot occur because count 0 is never granted.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, channel 0 highest through channel 3 lowest; the round-robin pointer is removed.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset, then load count[2]=3, raise dreq[2], hold hlda=1 one cycle after hrq:
  - hrq rises 1 cycle after dreq; dack=4'b0100 and dsel=2 one cycle after hlda.
  - After three xfer_done pulses: ch_done=4'b0100 for one cycle, hrq=0, cnt_rd(ch2)=0.
- Load count[0]=1 and count[1]=1, hold dreq=4'b0011 continuously:
  - Grant order is ch0 then ch1 (pointer advances).
  - Repeat with count[0]=2: second round grants ch1 before ch0.
  - With FIXED_PRIO_EN defined: ch0 always wins.
- dreq[3] with count[3]=0 -> no hrq ever. Write count[3]=5 -> hrq asserts.
- During XFER on ch1 with count=5: one xfer_done, then drop dreq[1] -> RELEASE, count[1]=4, no ch_done. Re-raise dreq[1] -> regrant with count 4.
- During XFER on ch0: cfg_we to ch0 with value 9 is ignored; a same-cycle cfg_we to ch2 with 7 is accepted.
- Assert reset low mid-XFER -> hrq, dack, busy drop asynchronously and all counts read 0.
- During XFER, drop hlda -> dack clears next edge. Leave hlda low -> IDLE the following cycle.
